// File: rtl/fu_mem_pipe.sv
// Load/store functional unit: registered memory request, fixed-latency tracking
// pipeline and an in-order result FIFO with occupancy-based back-pressure.
module fu_mem_pipe #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  output logic              ready,
  input  logic              mem_w,
  input  logic [2:0]        bhw,
  input  logic [ADDR_W-1:0] rs1_data,
  input  logic [31:0]       rs2_data,
  input  logic [ADDR_W-1:0] imm,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic              finish,
  input  logic              finish_ack,
  output logic [31:0]       mem_data,
  output logic [TAG_W-1:0]  tag_out,
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PW    = TAG_W + 7;

  logic              accept, pop, push;
  logic [ADDR_W-1:0] addr;
  logic              iss_err;
  logic [3:0]        iss_strb;
  logic [31:0]       iss_wdata;

  logic              req_q, req_d, we_q, we_d;
  logic [3:0]        strb_q, strb_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  assign accept = EN & ready;
  assign pop    = finish & finish_ack;

  always_comb begin
    addr      = rs1_data + imm;
    iss_err   = 1'b0;
    iss_strb  = 4'b0000;
    iss_wdata = rs2_data;
    case (bhw[1:0])
      2'b00: begin
        iss_strb  = 4'b0001 << addr[1:0];
        iss_wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        iss_strb  = 4'b0011 << {addr[1], 1'b0};
        iss_wdata = {2{rs2_data[15:0]}};
        iss_err   = addr[0];
      end
      2'b10: begin
        iss_strb = 4'b1111;
        iss_err  = |addr[1:0];
      end
      default: iss_err = 1'b1;
    endcase
    // Unsigned variants exist only for loads, and never for 11x encodings.
    if (bhw[2] && (mem_w || bhw[1])) iss_err = 1'b1;
    req_d  = accept & ~iss_err;
    we_d   = req_d & mem_w;
    strb_d = we_d ? iss_strb : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q  <= req_d;
      we_q   <= we_d;
      strb_q <= strb_d;
      if (accept) begin
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        wdata_q <= iss_wdata;
      end
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = strb_q;

  // Stage 0 coincides with the request cycle; stage LATENCY with the data cycle.
  logic [LATENCY:0] pv_q;
  logic [PW-1:0]    pd_q [LATENCY+1];

  always_ff @(posedge clk) begin
    if (!rst_n) pv_q <= '0;
    else        pv_q <= {pv_q[LATENCY-1:0], accept};
  end

  always_ff @(posedge clk) begin
    pd_q[0] <= {tag_in, iss_err, mem_w, bhw, addr[1:0]};
    for (int unsigned i = 1; i <= LATENCY; i++) pd_q[i] <= pd_q[i-1];
  end

  logic [PW-1:0]    tail;
  logic [1:0]       t_off;
  logic [2:0]       t_bhw;
  logic             t_w, t_err;
  logic [TAG_W-1:0] t_tag;
  logic [31:0]      shifted, res_d;

  assign push  = pv_q[LATENCY];
  assign tail  = pd_q[LATENCY];
  assign t_off = tail[1:0];
  assign t_bhw = tail[4:2];
  assign t_w   = tail[5];
  assign t_err = tail[6];
  assign t_tag = tail[PW-1:7];

  always_comb begin
    shifted = mem_rdata >> {t_off, 3'b000};
    res_d   = '0;
    if (!t_err && !t_w) begin
      case (t_bhw)
        3'b000:  res_d = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  res_d = {{16{shifted[15]}}, shifted[15:0]};
        3'b010:  res_d = mem_rdata;
        3'b100:  res_d = {24'b0, shifted[7:0]};
        3'b101:  res_d = {16'b0, shifted[15:0]};
        default: res_d = '0;
      endcase
    end
  end

  logic [31:0]      bdata_q [DEPTH];
  logic [TAG_W-1:0] btag_q  [DEPTH];
  logic             berr_q  [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] bcnt_q, occ_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      bcnt_q <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bdata_q[i] <= '0;
        btag_q[i]  <= '0;
        berr_q[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        bdata_q[wr_q] <= res_d;
        btag_q[wr_q]  <= t_tag;
        berr_q[wr_q]  <= t_err;
        wr_q          <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      bcnt_q <= bcnt_q + CNT_W'(push) - CNT_W'(pop);
      occ_q  <= occ_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  // Occupancy includes in-flight ops, so the buffer always has room on push.
  assign ready    = occ_q < CNT_W'(DEPTH);
  assign finish   = bcnt_q != '0;
  assign mem_data = bdata_q[rd_q];
  assign tag_out  = btag_q[rd_q];
  assign err      = berr_q[rd_q];

endmodule

// File: tb/tb_fu_mem_pipe.sv
// Self-checking bench for fu_mem_pipe: directed scenarios plus a randomized run
// against a queue-based reference model and a behavioural memory responder.
`timescale 1ns/1ps
module tb_fu_mem_pipe;
  localparam int unsigned LAT = 2;
  localparam int unsigned DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n, EN, ready, mem_w;
  logic [2:0]  bhw;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  tag_in, tag_out;
  logic        mem_req, mem_we, finish, finish_ack, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_data;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  fu_mem_pipe #(.ADDR_W(32), .LATENCY(LAT), .DEPTH(DEP), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .ready(ready), .mem_w(mem_w), .bhw(bhw),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .tag_in(tag_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .finish(finish),
    .finish_ack(finish_ack), .mem_data(mem_data), .tag_out(tag_out), .err(err)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_img [int unsigned];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory: a load request seen in cycle C is answered in cycle C+LAT.
  logic        hv [LAT+1];
  logic [31:0] ha [LAT+1];
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = (mem_req === 1'b1) && (mem_we === 1'b0);
    ha[0] = mem_addr;
    mem_rdata = (hv[LAT] === 1'b1) ? mem_word(ha[LAT]) : $urandom;
  end

  function automatic logic exp_err(input logic w, input logic [2:0] f, input logic [31:0] a);
    int unsigned size;
    if (w ? (f > 3'd2) : (f == 3'd3 || f >= 3'd6)) return 1'b1;
    size = 1 << (f % 4);
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    case (f)
      3'd0:    return ((v & 255) < 128) ? (v & 255) : (v & 255) + 32'hFFFF_FF00;
      3'd1:    return ((v & 32'hFFFF) < 32768) ? (v & 32'hFFFF) : (v & 32'hFFFF) + 32'hFFFF_0000;
      3'd2:    return w;
      3'd4:    return v & 255;
      default: return v & 32'hFFFF;
    endcase
  endfunction

  task automatic drive_op(input logic w, input logic [2:0] f, input logic [31:0] r1,
                          input logic [31:0] im, input logic [31:0] r2, input logic [4:0] t);
    EN = 1'b1; mem_w = w; bhw = f; rs1_data = r1; imm = im; rs2_data = r2; tag_in = t;
  endtask

  task automatic drive_idle();
    EN = 1'b0; mem_w = $urandom; bhw = $urandom; rs1_data = $urandom; imm = $urandom;
    rs2_data = $urandom; tag_in = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; finish_ack = 1'b0;
    drive_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd7);
    repeat (2) @(negedge clk);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL rst_finish: got %b want 0", finish); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_req: req=%b we=%b want 0 0", mem_req, mem_we); end
    checks++; if (mem_wstrb !== 4'b0) begin errors++; $display("FAIL rst_wstrb: got %b want 0000", mem_wstrb); end
    checks++; if (mem_data !== 32'h0 || tag_out !== 5'h0) begin errors++; $display("FAIL rst_head: data=%h tag=%h want 0 0", mem_data, tag_out); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
    rst_n = 1'b1; drive_idle();
    repeat (LAT + 3) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL rst_en_ignored: req=%b finish=%b want 0 0", mem_req, finish); end
    end
  endtask

  task automatic test_lw_basic();
    mem_img[32'h104] = 32'hDEADBEEF;
    drive_op(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd3);
    @(negedge clk); drive_idle();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h104) begin errors++; $display("FAIL lw_req: req=%b we=%b addr=%h want 1 0 104", mem_req, mem_we, mem_addr); end
    for (int k = 2; k <= LAT + 1; k++) begin
      @(negedge clk);
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL lw_early: finish=%b at +%0d want 0", finish, k); end
    end
    @(negedge clk);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL lw_finish: got %b want 1", finish); end
    checks++; if (mem_data !== 32'hDEADBEEF || tag_out !== 5'd3 || err !== 1'b0) begin errors++; $display("FAIL lw_result: data=%h tag=%0d err=%b want deadbeef 3 0", mem_data, tag_out, err); end
    finish_ack = 1'b1;
    @(negedge clk); finish_ack = 1'b0;
    checks++; if (finish !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL lw_pop: finish=%b ready=%b want 0 1", finish, ready); end
  endtask

  task automatic test_load_ext();
    logic [31:0] ex [3];
    logic [2:0]  f  [3];
    logic [31:0] o  [3];
    mem_img[32'h100] = 32'h80FF_FF7F;
    f[0] = 3'b000; o[0] = 32'h3; ex[0] = 32'hFFFF_FF80;
    f[1] = 3'b100; o[1] = 32'h3; ex[1] = 32'h0000_0080;
    f[2] = 3'b101; o[2] = 32'h2; ex[2] = 32'h0000_80FF;
    for (int k = 0; k <= LAT + 5; k++) begin
      if (k < 3) drive_op(1'b0, f[k], 32'h100, o[k], 32'h0, 5'(20 + k));
      else drive_idle();
      if (k >= 1 && k <= 3) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL ext_req%0d: req=%b addr=%h want 1 100", k - 1, mem_req, mem_addr); end
      end
      finish_ack = 1'b0;
      if (k >= LAT + 2 && k < LAT + 5) begin
        checks++; if (finish !== 1'b1 || mem_data !== ex[k-LAT-2] || err !== 1'b0 || tag_out !== 5'(18 + k - LAT)) begin
          errors++; $display("FAIL ext_res%0d: fin=%b data=%h err=%b tag=%0d want 1 %h 0 %0d", k - LAT - 2, finish, mem_data, err, tag_out, ex[k-LAT-2], 18 + k - LAT);
        end
        finish_ack = 1'b1;
      end
      if (k == LAT + 5) begin
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL ext_drained: finish=%b want 0", finish); end
      end
      @(negedge clk);
    end
    finish_ack = 1'b0;
  endtask

  task automatic test_store_half();
    drive_op(1'b1, 3'b001, 32'h200, 32'h2, 32'h1234ABCD, 5'd9);
    @(negedge clk); drive_idle();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL sh_req: req=%b we=%b addr=%h want 1 1 200", mem_req, mem_we, mem_addr); end
    checks++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_lane: strb=%b wdata=%h want 1100 abcdabcd", mem_wstrb, mem_wdata); end
    repeat (LAT + 1) @(negedge clk);
    checks++; if (finish !== 1'b1 || mem_data !== 32'h0 || err !== 1'b0 || tag_out !== 5'd9) begin errors++; $display("FAIL sh_result: fin=%b data=%h err=%b tag=%0d want 1 0 0 9", finish, mem_data, err, tag_out); end
    finish_ack = 1'b1;
    @(negedge clk); finish_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    logic        w  [3];
    logic [2:0]  f  [3];
    logic [31:0] o  [3];
    w[0] = 1'b0; f[0] = 3'b010; o[0] = 32'h1;
    w[1] = 1'b0; f[1] = 3'b011; o[1] = 32'h0;
    w[2] = 1'b1; f[2] = 3'b100; o[2] = 32'h0;
    for (int k = 0; k <= LAT + 5; k++) begin
      if (k < 3) drive_op(w[k], f[k], 32'h100, o[k], 32'hFFFF_FFFF, 5'(28 + k));
      else drive_idle();
      if (k >= 1 && k <= 3) begin
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL bad_req%0d: req=%b we=%b want 0 0", k - 1, mem_req, mem_we); end
      end
      finish_ack = 1'b0;
      if (k >= LAT + 2 && k < LAT + 5) begin
        checks++; if (finish !== 1'b1 || err !== 1'b1 || mem_data !== 32'h0 || tag_out !== 5'(26 + k - LAT)) begin
          errors++; $display("FAIL bad_res%0d: fin=%b err=%b data=%h tag=%0d want 1 1 0 %0d", k - LAT - 2, finish, err, mem_data, tag_out, 26 + k - LAT);
        end
        finish_ack = 1'b1;
      end
      @(negedge clk);
    end
    finish_ack = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    int unsigned acc = 0;
    finish_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++; if (ready !== 1'(k < DEP)) begin errors++; $display("FAIL fill_ready%0d: got %b want %0d", k, ready, k < DEP); end
      if (ready === 1'b1) acc++;
      drive_op(1'b0, 3'b010, 32'h400 + 32'(4 * k), 32'h0, 32'h0, 5'(10 + k));
      @(negedge clk);
    end
    drive_idle();
    checks++; if (acc != DEP) begin errors++; $display("FAIL fill_count: accepted %0d want %0d", acc, DEP); end
    checks++; if (ready !== 1'b0 || finish !== 1'b1 || tag_out !== 5'd10) begin errors++; $display("FAIL fill_full: ready=%b fin=%b tag=%0d want 0 1 10", ready, finish, tag_out); end
    finish_ack = 1'b1;
    @(negedge clk); finish_ack = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fill_ack_ready: got %b want 1", ready); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (finish !== 1'b1 || tag_out !== 5'(10 + k)) begin errors++; $display("FAIL fill_order%0d: fin=%b tag=%0d want 1 %0d", k, finish, tag_out, 10 + k); end
      finish_ack = 1'b1;
      @(negedge clk);
    end
    finish_ack = 1'b0;
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL fill_drained: finish=%b want 0", finish); end
  endtask

  task automatic test_reset_midflight();
    finish_ack = 1'b0;
    for (int k = 0; k <= LAT + 8; k++) begin
      if (k < 2) drive_op(1'b0, 3'b010, 32'h800, 32'(4 * k), 32'h0, 5'(5 + k));
      else drive_idle();
      rst_n = (k == LAT) ? 1'b0 : 1'b1;
      if (k == LAT + 1) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready); end
      end
      if (k >= LAT + 1) begin
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL midrst_finish%0d: got %b want 0", k, finish); end
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    int unsigned avail;
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } res_t;

  task automatic test_random();
    res_t        q [$];
    res_t        r;
    logic        pend_req = 1'b0, pend_we = 1'b0, exp_ready, exp_fin, ack;
    logic [31:0] pend_addr = '0, pend_wdata = '0, a;
    logic [3:0]  pend_strb = '0;
    int unsigned size;
    for (int k = 0; k < 460; k++) begin
      checks++; if (mem_req !== pend_req || mem_we !== pend_we) begin errors++; $display("FAIL rnd_req@%0d: req=%b we=%b want %b %b", cyc, mem_req, mem_we, pend_req, pend_we); end
      if (pend_req) begin
        checks++; if (mem_addr !== pend_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, mem_addr, pend_addr); end
      end
      if (pend_we) begin
        checks++; if (mem_wstrb !== pend_strb || mem_wdata !== pend_wdata) begin errors++; $display("FAIL rnd_store@%0d: strb=%b wdata=%h want %b %h", cyc, mem_wstrb, mem_wdata, pend_strb, pend_wdata); end
      end
      exp_ready = q.size() < DEP;
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, ready, exp_ready); end
      exp_fin = (q.size() > 0) && (q[0].avail <= cyc);
      checks++; if (finish !== exp_fin) begin errors++; $display("FAIL rnd_finish@%0d: got %b want %b", cyc, finish, exp_fin); end
      if (exp_fin) begin
        checks++; if (mem_data !== q[0].data || tag_out !== q[0].tag || err !== q[0].err) begin
          errors++; $display("FAIL rnd_head@%0d: data=%h tag=%0d err=%b want %h %0d %b", cyc, mem_data, tag_out, err, q[0].data, q[0].tag, q[0].err);
        end
      end
      ack = (k >= 400) || ($urandom % 3 != 0);
      finish_ack = ack;
      if (exp_fin && ack) void'(q.pop_front());
      pend_req = 1'b0; pend_we = 1'b0;
      if (k < 400 && ($urandom % 4 != 0)) begin
        drive_op($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        if (exp_ready) begin
          a = rs1_data + imm;
          r.avail = cyc + LAT + 2;
          r.tag   = tag_in;
          r.err   = exp_err(mem_w, bhw, a);
          r.data  = (r.err || mem_w) ? 32'h0 : exp_load(bhw, a, mem_word(a & 32'hFFFF_FFFC));
          q.push_back(r);
          pend_req  = !r.err;
          pend_we   = !r.err && mem_w;
          pend_addr = a & 32'hFFFF_FFFC;
          size      = 1 << (bhw % 4);
          pend_strb = 4'(((1 << size) - 1) << (a % 4));
          pend_wdata = (bhw % 4 == 0) ? (rs2_data & 255) * 32'h0101_0101 :
                       (bhw % 4 == 1) ? (rs2_data & 32'hFFFF) * 32'h0001_0001 : rs2_data;
        end
      end else begin
        drive_idle();
      end
      @(negedge clk);
    end
    finish_ack = 1'b0;
    checks++; if (finish !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rnd_drain: finish=%b model_left=%0d want 0 0", finish, q.size()); end
  endtask

  initial begin
    for (int i = 0; i <= LAT; i++) begin hv[i] = 1'b0; ha[i] = '0; end
    rst_n = 1'b0; finish_ack = 1'b0; mem_rdata = '0;
    drive_idle();
    test_reset();
    test_lw_basic();
    test_load_ext();
    test_store_half();
    test_misaligned();
    test_fill_backpressure();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_mem_pipe.md
FU_MEM_PIPE -- requirements
Module: fu_mem_pipe

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; LATENCY, default 2, memory read latency in cycles (>=1); DEPTH, default 4, max ops in flight plus buffered (power of 2, >=2); TAG_W, default 5, issue tag width.
REQ-002 SHALL use one clock; reset is synchronous and active-low; ports are clk and rst_n.
REQ-003 SHALL have ports, one per line: name direction width meaning.
 clk  in  1  rising-edge clock
 rst_n  in  1  synchronous active-low reset
 EN  in  1  issue valid
 ready  out  1  unit can accept an issue this cycle
 mem_w  in  1  1=store, 0=load
 bhw  in  3  RISC-V funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
 rs1_data  in  ADDR_W  base address
 rs2_data  in  32  store data
 imm  in  ADDR_W  offset
 tag_in  in  TAG_W  issue tag
 mem_req  out  1  memory access strobe
 mem_we  out  1  memory write enable
 mem_addr  out  ADDR_W  word-aligned address
 mem_wdata  out  32  lane-aligned store data
 mem_wstrb  out  4  byte write strobes
 mem_rdata  in  32  read word, valid LATENCY cycles after mem_req
 finish  out  1  result valid at head of result buffer
 finish_ack  in  1  consumer takes result
 mem_data  out  32  extended load result (0 for stores/errors)
 tag_out  out  TAG_W  tag of head result
 err  out  1  head op was misaligned or illegal bhw

Function
REQ-010 Issue accepted at a rising edge where EN & ready; operands, tag, mem_w, bhw and addr = rs1_data + imm (mod 2^ADDR_W) SHALL be registered at that edge.
REQ-011 occupancy = ops in memory pipeline + entries in result buffer; ready SHALL be 1 iff registered occupancy < DEPTH; ready SHALL NOT depend combinationally on finish_ack or EN.
REQ-012 mem_req, mem_we, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wdata, mem_wstrb SHALL be driven from registers in the cycle after acceptance, for exactly one cycle; back-to-back issues produce back-to-back requests.
REQ-013 Store lanes: sb wstrb=0001<<addr[1:0], wdata=byte replicated x4; sh wstrb=0011<<{addr[1],1'b0}, wdata=half replicated x2; sw wstrb=1111, wdata=rs2_data.
REQ-014 Load result SHALL be mem_rdata shifted right by addr[1:0]*8 then sign-extended (lb/lh) or zero-extended (lbu/lhu); lw unmodified.
REQ-015 Error: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0, or bhw in {011,110,111} (loads) / bhw not in {000,001,010} (stores); such op SHALL hold mem_req=0 in its request cycle, still occupy a slot, and complete with err=1, mem_data=0.
REQ-016 Every op (load, store, error) SHALL traverse a LATENCY-stage tracking pipeline; its result is written into the result buffer at the edge ending the cycle mem_rdata is valid.
REQ-017 Result buffer SHALL be a DEPTH-entry FIFO; results leave in issue order; finish = buffer non-empty; mem_data/tag_out/err show head entry, registered.
REQ-018 Minimum latency: finish SHALL rise in cycle T+LATENCY+2 for an op accepted at edge ending cycle T, with empty buffer.
REQ-019 Head popped at edge where finish & finish_ack; finish_ack with finish=0 SHALL be ignored.
REQ-020 Simultaneous accept, pipeline write and pop in one cycle SHALL all take effect; occupancy updated +1/-1 accordingly.
REQ-021 Buffer SHALL never overflow: occupancy bound of REQ-011 guarantees space for every in-flight op.

Reset
REQ-030 At an edge with rst_n=0: pipeline and buffer cleared, occupancy=0, finish=0, err=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_data=0, tag_out=0; ready=1 in the next cycle.
REQ-031 Reset mid-operation SHALL discard all outstanding ops; mem_rdata returning afterwards SHALL be ignored.
REQ-032 EN while rst_n=0 SHALL be ignored.

Verification
REQ-040 lw rs1=0x100 imm=4 tag=3, LATENCY=2, mem_rdata=0xDEADBEEF -> mem_req with mem_addr=0x104 next cycle; finish at T+4, mem_data=0xDEADBEEF, tag_out=3, err=0.
REQ-041 lb addr=0x103, rdata=0x80FF_FF7F -> mem_data=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x102 -> 0x000080FF.
REQ-042 sh rs2=0x1234ABCD addr=0x202 -> mem_we=1, mem_wstrb=1100, mem_wdata=0xABCDABCD; finish with mem_data=0, err=0.
REQ-043 lw addr=0x101 -> mem_req stays 0, finish at same latency with err=1, mem_data=0.
REQ-044 EN held 1, finish_ack=0, DEPTH=4 -> exactly 4 accepted, ready=0 thereafter; one finish_ack -> ready=1 next cycle; results tags in issue order.
REQ-045 Issue 2 loads, assert rst_n=0 one cycle before their data returns -> no finish afterwards, ready=1, later mem_rdata ignored.
